// File: rtl/exec_stage_wide.sv
// Execute stage: single-cycle ALU/branch/memory-address ops plus an optional
// multi-cycle shift-add multiplier. Every result is registered and appears as
// a one-cycle out_valid pulse. Handshake: an instruction is accepted on a
// rising clk edge where in_valid and in_ready are both high; in_ready is low
// only while a multiply is running; there is no downstream backpressure.
module exec_stage_wide #(
   parameter int DATA_W = 16,
   parameter int IMM_W  = 7,
   parameter int IDX_W  = 5,
   parameter int MUL_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        control_in,
   input  logic [IDX_W-1:0]  dest_index_in,
   input  logic [DATA_W-1:0] reg1_data,
   input  logic [DATA_W-1:0] reg2_data,
   input  logic [DATA_W-1:0] npc,
   input  logic [IMM_W-1:0]  immediate,
   output logic              out_valid,
   output logic [4:0]        control_out,
   output logic [IDX_W-1:0]  dest_index_out,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] output_reg,
   output logic [DATA_W-1:0] target,
   output logic              branch_taken,
   output logic              DEST_REG_WRITE_EN,
   output logic              ZF,
   output logic              GF,
   output logic              LF,
   output logic              busy
);

   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_ADD    = 5'b00010;
   localparam logic [4:0] OP_ADDI   = 5'b00011;
   localparam logic [4:0] OP_SHLLI  = 5'b00100;
   localparam logic [4:0] OP_SHRLI  = 5'b00101;
   localparam logic [4:0] OP_JUMP   = 5'b00110;
   localparam logic [4:0] OP_JUMPL  = 5'b00111;
   localparam logic [4:0] OP_JUMPG  = 5'b01000;
   localparam logic [4:0] OP_JUMPE  = 5'b01001;
   localparam logic [4:0] OP_JUMPNE = 5'b01010;
   localparam logic [4:0] OP_CMP    = 5'b01011;
   localparam logic [4:0] OP_LOAD   = 5'b01100;
   localparam logic [4:0] OP_LOADI  = 5'b01101;
   localparam logic [4:0] OP_STORE  = 5'b01110;
   localparam logic [4:0] OP_MOV    = 5'b01111;
   localparam logic [4:0] OP_MUL    = 5'b10000;

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

   state_t state_q, state_d;

   logic              out_valid_q;
   logic [4:0]        control_q;
   logic [IDX_W-1:0]  dest_q;
   logic [DATA_W-1:0] result_q, oreg_q, target_q;
   logic              branch_q, wen_q;
   logic              zf_q, gf_q, lf_q;

   // Multiplier working registers and the instruction tag held until completion
   logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic [4:0]        mul_ctrl_q;
   logic [IDX_W-1:0]  mul_dest_q;

   logic              accept, is_mul, mul_last, shamt_big;
   logic [DATA_W-1:0] simm, zimm;
   logic [DATA_W-1:0] res_d, oreg_d, tgt_d;
   logic              br_d, wen_d;

   assign simm      = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
   assign zimm      = {{(DATA_W-IMM_W){1'b0}}, immediate};
   assign shamt_big = (32'(immediate) >= 32'(DATA_W));
   assign accept    = in_valid && (state_q == S_IDLE);
   assign is_mul    = (MUL_EN != 0) && (control_in == OP_MUL);
   assign mul_last  = (state_q == S_MUL_BUSY) && (cnt_q == CNT_W'(DATA_W-1));
   assign acc_nxt   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: a multiply holds the stage for DATA_W iterations
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (accept && is_mul) state_d = S_MUL_BUSY;
         S_MUL_BUSY: if (mul_last)         state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // FSM outputs: ready only when idle; busy doubles as the visible state
   always_comb begin
      in_ready = (state_q == S_IDLE);
      busy     = (state_q == S_MUL_BUSY);
   end

   // Single-cycle result decode; unlisted opcodes (and disabled MUL) give NOP zeros
   always_comb begin
      res_d  = '0;
      oreg_d = '0;
      tgt_d  = '0;
      br_d   = 1'b0;
      wen_d  = 1'b0;
      case (control_in)
         OP_SUB:    begin res_d = reg1_data - reg2_data; wen_d = 1'b1; end
         OP_ADD:    begin res_d = reg1_data + reg2_data; wen_d = 1'b1; end
         OP_ADDI:   begin res_d = reg1_data + simm;      wen_d = 1'b1; end
         OP_SHLLI:  begin res_d = shamt_big ? '0 : (reg1_data << immediate); wen_d = 1'b1; end
         OP_SHRLI:  begin res_d = shamt_big ? '0 : (reg1_data >> immediate); wen_d = 1'b1; end
         OP_JUMP:   begin tgt_d = npc + simm; br_d = 1'b1;  end
         OP_JUMPL:  begin tgt_d = npc + simm; br_d = lf_q;  end
         OP_JUMPG:  begin tgt_d = npc + simm; br_d = gf_q;  end
         OP_JUMPE:  begin tgt_d = npc + simm; br_d = zf_q;  end
         OP_JUMPNE: begin tgt_d = npc + simm; br_d = !zf_q; end
         OP_LOAD:   begin res_d = reg1_data + simm; wen_d = 1'b1; end
         OP_LOADI:  begin res_d = zimm;             wen_d = 1'b1; end
         OP_STORE:  begin res_d = reg1_data + simm; oreg_d = reg2_data; end
         OP_MOV:    begin res_d = reg1_data;        wen_d = 1'b1; end
         default:   ;
      endcase
   end

   // Datapath: flags, output registers and the shift-add multiplier
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         control_q   <= '0;
         dest_q      <= '0;
         result_q    <= '0;
         oreg_q      <= '0;
         target_q    <= '0;
         branch_q    <= 1'b0;
         wen_q       <= 1'b0;
         zf_q        <= 1'b0;
         gf_q        <= 1'b0;
         lf_q        <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mul_ctrl_q  <= '0;
         mul_dest_q  <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            if (control_in == OP_CMP) begin
               zf_q <= (reg1_data == reg2_data);
               gf_q <= (reg1_data >  reg2_data);
               lf_q <= (reg1_data <  reg2_data);
            end
            if (is_mul) begin
               mcand_q    <= reg1_data;
               mplier_q   <= reg2_data;
               acc_q      <= '0;
               cnt_q      <= '0;
               mul_ctrl_q <= control_in;
               mul_dest_q <= dest_index_in;
            end else begin
               out_valid_q <= 1'b1;
               control_q   <= control_in;
               dest_q      <= dest_index_in;
               result_q    <= res_d;
               oreg_q      <= oreg_d;
               target_q    <= tgt_d;
               branch_q    <= br_d;
               wen_q       <= wen_d;
            end
         end else if (state_q == S_MUL_BUSY) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (mul_last) begin
               out_valid_q <= 1'b1;
               control_q   <= mul_ctrl_q;
               dest_q      <= mul_dest_q;
               result_q    <= acc_nxt;
               oreg_q      <= '0;
               target_q    <= '0;
               branch_q    <= 1'b0;
               wen_q       <= 1'b1;
            end
         end
      end
   end

   assign out_valid         = out_valid_q;
   assign control_out       = control_q;
   assign dest_index_out    = dest_q;
   assign result_out        = result_q;
   assign output_reg        = oreg_q;
   assign target            = target_q;
   assign branch_taken      = branch_q;
   assign DEST_REG_WRITE_EN = wen_q;
   assign ZF                = zf_q;
   assign GF                = gf_q;
   assign LF                = lf_q;

endmodule

// File: tb/tb_exec_stage_wide.sv
// Bench for exec_stage_wide: directed instructions with hand-computed results;
// a negedge monitor pops the expected queue on every out_valid pulse and also
// checks the cycle on which each result arrives.
module tb_exec_stage_wide;

   localparam int DATA_W = 16;
   localparam int IMM_W  = 7;
   localparam int IDX_W  = 5;
   localparam int EXP_W  = 5 + IDX_W + 3*DATA_W + 2;

   localparam logic [4:0] OP_NOP    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_ADD    = 5'b00010;
   localparam logic [4:0] OP_ADDI   = 5'b00011;
   localparam logic [4:0] OP_SHLLI  = 5'b00100;
   localparam logic [4:0] OP_SHRLI  = 5'b00101;
   localparam logic [4:0] OP_JUMP   = 5'b00110;
   localparam logic [4:0] OP_JUMPL  = 5'b00111;
   localparam logic [4:0] OP_JUMPG  = 5'b01000;
   localparam logic [4:0] OP_JUMPE  = 5'b01001;
   localparam logic [4:0] OP_JUMPNE = 5'b01010;
   localparam logic [4:0] OP_CMP    = 5'b01011;
   localparam logic [4:0] OP_LOAD   = 5'b01100;
   localparam logic [4:0] OP_LOADI  = 5'b01101;
   localparam logic [4:0] OP_STORE  = 5'b01110;
   localparam logic [4:0] OP_MOV    = 5'b01111;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_BAD    = 5'b10101;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready;
   logic [4:0]        control_in;
   logic [IDX_W-1:0]  dest_index_in;
   logic [DATA_W-1:0] reg1_data, reg2_data, npc;
   logic [IMM_W-1:0]  immediate;
   logic              out_valid;
   logic [4:0]        control_out;
   logic [IDX_W-1:0]  dest_index_out;
   logic [DATA_W-1:0] result_out, output_reg, target;
   logic              branch_taken, DEST_REG_WRITE_EN, ZF, GF, LF, busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int seq   = 1;

   logic [EXP_W-1:0] exp_q[$];
   int               exp_cyc_q[$];
   logic [EXP_W-1:0] mon_exp;
   int               mon_cyc;

   exec_stage_wide #(.DATA_W(DATA_W), .IMM_W(IMM_W), .IDX_W(IDX_W), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .control_in(control_in), .dest_index_in(dest_index_in),
      .reg1_data(reg1_data), .reg2_data(reg2_data), .npc(npc), .immediate(immediate),
      .out_valid(out_valid), .control_out(control_out), .dest_index_out(dest_index_out),
      .result_out(result_out), .output_reg(output_reg), .target(target),
      .branch_taken(branch_taken), .DEST_REG_WRITE_EN(DEST_REG_WRITE_EN),
      .ZF(ZF), .GF(GF), .LF(LF), .busy(busy)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every out_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid: got op %05b result %0h, required no output",
                     control_out, result_out);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_cyc = exp_cyc_q.pop_front();
            check($sformatf("out_fields_op%05b", mon_exp[EXP_W-1 -: 5]),
                  64'({control_out, dest_index_out, result_out, output_reg, target,
                       branch_taken, DEST_REG_WRITE_EN}), 64'(mon_exp));
            check($sformatf("out_cycle_op%05b", mon_exp[EXP_W-1 -: 5]), 64'(cyc), 64'(mon_cyc));
         end
      end
   end

   // Driver: present one instruction; it is accepted on the following posedge
   task automatic send(input logic [4:0] op, input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                       input logic [DATA_W-1:0] pc, input logic [IMM_W-1:0] imm,
                       input logic [DATA_W-1:0] e_res, input logic [DATA_W-1:0] e_oreg,
                       input logic [DATA_W-1:0] e_tgt, input logic e_br, input logic e_wen,
                       input bit exp_out);
      logic [IDX_W-1:0] d;
      @(negedge clk);
      d = IDX_W'(seq);
      seq++;
      control_in    = op;
      dest_index_in = d;
      reg1_data     = r1;
      reg2_data     = r2;
      npc           = pc;
      immediate     = imm;
      in_valid      = 1'b1;
      if (exp_out) begin
         exp_q.push_back({op, d, e_res, e_oreg, e_tgt, e_br, e_wen});
         exp_cyc_q.push_back(cyc + ((op == OP_MUL) ? 1 + DATA_W : 1));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // While a multiply runs, offer junk that must be ignored; count stalled cycles
   task automatic wait_mul(input int exp_low);
      int low;
      bit done;
      low  = 0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            in_valid = 1'b0;
            done     = 1'b1;
         end else begin
            low++;
            if (low == 1) check("busy_during_mul", 64'(busy), 64'(1));
            in_valid   = 1'b1;
            control_in = OP_ADD;
            reg1_data  = DATA_W'($urandom_range(0, 65535));
            reg2_data  = DATA_W'($urandom_range(0, 65535));
         end
      end
      check("mul_stall_cycles", 64'(low), 64'(exp_low));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; control_in = '0; dest_index_in = '0;
      reg1_data = '0; reg2_data = '0; npc = '0; immediate = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_flags",     64'({ZF, GF, LF}), 64'(0));
      check("rst_data", 64'({control_out, dest_index_out, result_out, output_reg, target,
                             branch_taken, DEST_REG_WRITE_EN}), 64'(0));
      rst = 1'b0;

      // Arithmetic, shifts and shift boundaries
      send(OP_SUB,   16'd10,     16'd3, 16'd0, 7'h00, 16'd7,      16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_ADDI,  16'd10,     16'd0, 16'd0, 7'h7F, 16'd9,      16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_SHLLI, 16'd8,      16'd0, 16'd0, 7'd1,  16'd16,     16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_SHRLI, 16'd8,      16'd0, 16'd0, 7'd1,  16'd4,      16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_SHRLI, 16'd8,      16'd0, 16'd0, 7'd20, 16'd0,      16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_SHLLI, 16'd1,      16'd0, 16'd0, 7'd15, 16'h8000,   16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_SHLLI, 16'd1,      16'd0, 16'd0, 7'd16, 16'd0,      16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_ADD,   16'hFFFF,   16'd2, 16'd0, 7'd0,  16'd1,      16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      send(OP_SUB,   16'd3,      16'd5, 16'd0, 7'd0,  16'hFFFE,   16'd0, 16'd0, 1'b0, 1'b1, 1'b1);

      // Compare then dependent branch on the very next edge
      send(OP_CMP,   16'd4,      16'd8, 16'd0, 7'd0,  16'd0,      16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      send(OP_JUMPL, 16'd0,      16'd0, 16'd5, 7'd1,  16'd0,      16'd0, 16'd6, 1'b1, 1'b0, 1'b1);
      idle(1);
      check("flags_after_cmp_4_8", 64'({ZF, GF, LF}), 64'(3'b001));
      send(OP_CMP,    16'd7,     16'd7, 16'd0,     7'd0,  16'd0,  16'd0, 16'd0,     1'b0, 1'b0, 1'b1);
      send(OP_JUMPNE, 16'd0,     16'd0, 16'h0100,  7'h7E, 16'd0,  16'd0, 16'h00FE,  1'b0, 1'b0, 1'b1);
      send(OP_JUMPE,  16'd0,     16'd0, 16'h0100,  7'd2,  16'd0,  16'd0, 16'h0102,  1'b1, 1'b0, 1'b1);
      send(OP_JUMPG,  16'd0,     16'd0, 16'd0,     7'd0,  16'd0,  16'd0, 16'd0,     1'b0, 1'b0, 1'b1);
      idle(1);
      check("flags_after_cmp_7_7", 64'({ZF, GF, LF}), 64'(3'b100));

      // Memory-address ops, moves, undefined opcode, unconditional jump
      send(OP_LOAD,  16'd100,    16'd0,     16'd0, 7'h7C, 16'd96,    16'd0,     16'd0,     1'b0, 1'b1, 1'b1);
      send(OP_LOADI, 16'd0,      16'd0,     16'd0, 7'h7F, 16'd127,   16'd0,     16'd0,     1'b0, 1'b1, 1'b1);
      send(OP_MOV,   16'h1234,   16'd0,     16'd0, 7'd0,  16'h1234,  16'd0,     16'd0,     1'b0, 1'b1, 1'b1);
      send(OP_STORE, 16'd100,    16'hBEEF,  16'd0, 7'h7C, 16'd96,    16'hBEEF,  16'd0,     1'b0, 1'b0, 1'b1);
      send(OP_BAD,   16'd5,      16'd6,     16'd7, 7'd3,  16'd0,     16'd0,     16'd0,     1'b0, 1'b0, 1'b1);
      send(OP_NOP,   16'd5,      16'd6,     16'd7, 7'd3,  16'd0,     16'd0,     16'd0,     1'b0, 1'b0, 1'b1);
      send(OP_JUMP,  16'd0,      16'd0,     16'd0, 7'h40, 16'd0,     16'd0,     16'hFFC0,  1'b1, 1'b0, 1'b1);
      send(OP_CMP,   16'd9,      16'd2,     16'd0, 7'd0,  16'd0,     16'd0,     16'd0,     1'b0, 1'b0, 1'b1);
      send(OP_JUMPG, 16'd0,      16'd0,     16'h10, 7'h10, 16'd0,    16'd0,     16'h20,    1'b1, 1'b0, 1'b1);
      idle(1);
      check("flags_after_cmp_9_2", 64'({ZF, GF, LF}), 64'(3'b010));

      // Multiplies: 300*300 = 90000 -> 0x5F90 low bits; 0xFFFF^2 -> 1 low bits
      send(OP_MUL, 16'd300,  16'd300,  16'd0, 7'd0, 16'h5F90, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      wait_mul(DATA_W);
      send(OP_MUL, 16'hFFFF, 16'hFFFF, 16'd0, 7'd0, 16'd1,    16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      wait_mul(DATA_W);
      check("flags_kept_through_mul", 64'({ZF, GF, LF}), 64'(3'b010));

      // Reset five cycles into a multiply: no result, idle, flags cleared
      send(OP_MUL, 16'd300, 16'd300, 16'd0, 7'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      idle(4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", 64'(in_ready), 64'(1));
      check("abort_busy",     64'(busy),     64'(0));
      check("abort_flags",    64'({ZF, GF, LF}), 64'(0));
      check("abort_result",   64'(result_out), 64'(0));
      send(OP_ADD, 16'd10, 16'd5, 16'd0, 7'd0, 16'd15, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      idle(25);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("pending_results", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
